// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue instruction fetch queue.
package fetch_pkg;
  localparam int          INSTR_W      = 32;
  localparam int          LANES        = 2;
  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fq_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of {instr, pc}: up to 2 pushes and 2 pops per cycle, exposes the two oldest entries.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [1:0]             push_n,
  input  fq_entry_t [LANES-1:0]  push_data,
  input  logic [1:0]             pop_m,
  output fq_entry_t [LANES-1:0]  head_data,
  output logic [CW-1:0]          count
);
  fq_entry_t      mem [DEPTH];
  logic [AW-1:0]  head, tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop_m);
      tail  <= tail + AW'(push_n);
      count <= count + CW'(push_n) - CW'(pop_m);
    end
  end

  // Storage is not reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++)
      if (push_n > 2'(l)) mem[tail + AW'(l)] <= push_data[l];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_head
    assign head_data[l] = mem[head + AW'(l)];
  end
endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: owns the PC, pushes the two fetched words into fetch_fifo, pops for decode, handles redirects.
module ifetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [31:0]   imem_addr,
  input  logic [31:0]   imem_rd,
  input  logic [31:0]   imem_rd2,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  input  logic [1:0]    deq_count,
  output logic          out_valid0,
  output logic [31:0]   out_instr0,
  output logic [31:0]   out_pc0,
  output logic          out_valid1,
  output logic [31:0]   out_instr1,
  output logic [31:0]   out_pc1,
  output logic [CW-1:0] count
);
  logic [31:0]           pc, tgt;
  logic [CW-1:0]         free;
  logic [1:0]            deq_c, push_n, pop_m;
  logic [LANES-1:0]      vld;
  fq_entry_t [LANES-1:0] push_data, head_data;

  assign imem_addr = pc;
  assign tgt       = redirect_pc & ~32'h3;
  assign free      = CW'(DEPTH) - count;
  assign deq_c     = (deq_count == 2'd3) ? 2'd2 : deq_count;

  // Space freed by this cycle's pops is only usable next cycle.
  always_comb begin
    push_n = 2'd0;
    pop_m  = 2'd0;
    if (!redirect) begin
      push_n = (free >= CW'(2)) ? 2'd2 : free[1:0];
      pop_m  = (CW'(deq_c) > count) ? count[1:0] : deq_c;
    end
  end

  assign push_data[0] = '{instr: imem_rd,  pc: pc};
  assign push_data[1] = '{instr: imem_rd2, pc: pc + 32'd4};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pc <= RESET_PC;
    else if (redirect) pc <= tgt;
    else               pc <= pc + {28'd0, push_n, 2'b00};
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push_n    (push_n),
    .push_data (push_data),
    .pop_m     (pop_m),
    .head_data (head_data),
    .count     (count)
  );

  for (genvar l = 0; l < LANES; l++) begin : g_vld
    assign vld[l] = count > CW'(l);
  end

  assign out_valid0 = vld[0];
  assign out_valid1 = vld[1];
  assign out_instr0 = vld[0] ? head_data[0].instr : NOP;
  assign out_pc0    = vld[0] ? head_data[0].pc    : 32'd0;
  assign out_instr1 = vld[1] ? head_data[1].instr : NOP;
  assign out_pc1    = vld[1] ? head_data[1].pc    : 32'd0;
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: stimulus pushes expected post-edge state, a monitor pops and compares.
module tb_ifetch_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_rd, imem_rd2;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  deq_count;
  logic        out_valid0, out_valid1;
  logic [31:0] out_instr0, out_pc0, out_instr1, out_pc1;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory image: word at byte address a is 32'h1000_0000 + a/4.
  assign imem_rd  = 32'h1000_0000 + (imem_addr >> 2);
  assign imem_rd2 = 32'h1000_0000 + ((imem_addr + 32'd4) >> 2);

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_rd2(imem_rd2),
    .redirect(redirect), .redirect_pc(redirect_pc), .deq_count(deq_count),
    .out_valid0(out_valid0), .out_instr0(out_instr0), .out_pc0(out_pc0),
    .out_valid1(out_valid1), .out_instr1(out_instr1), .out_pc1(out_pc1), .count(count)
  );

  typedef struct {
    int          deq;
    bit          redir;
    logic [31:0] rpc;
    bit          prst;
    int          cnt;
    logic [31:0] addr, pc0, pc1;
  } vec_t;

  vec_t vecs[$];
  vec_t expq[$];

  task automatic add(int d, bit r, logic [31:0] rp, bit pr, int c,
                     logic [31:0] a, logic [31:0] p0, logic [31:0] p1);
    vec_t v;
    v.deq = d; v.redir = r; v.rpc = rp; v.prst = pr;
    v.cnt = c; v.addr = a; v.pc0 = p0; v.pc1 = p1;
    vecs.push_back(v);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  task automatic chk_idle(string tag);
    chk({tag, ".count"},  32'(count), 32'd0);
    chk({tag, ".addr"},   imem_addr, 32'h0);
    chk({tag, ".v0"},     32'(out_valid0), 32'd0);
    chk({tag, ".v1"},     32'(out_valid1), 32'd0);
    chk({tag, ".instr0"}, out_instr0, 32'd0);
    chk({tag, ".pc1"},    out_pc1, 32'd0);
  endtask

  // Monitor: compares the DUT against the queued expectation after each edge.
  initial begin
    vec_t e;
    int   n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        n++;
        chk($sformatf("v%0d.count", n),  32'(count), 32'(e.cnt));
        chk($sformatf("v%0d.addr", n),   imem_addr, e.addr);
        chk($sformatf("v%0d.v0", n),     32'(out_valid0), 32'(e.cnt >= 1));
        chk($sformatf("v%0d.v1", n),     32'(out_valid1), 32'(e.cnt >= 2));
        chk($sformatf("v%0d.pc0", n),    out_pc0, e.pc0);
        chk($sformatf("v%0d.pc1", n),    out_pc1, e.pc1);
        chk($sformatf("v%0d.instr0", n), out_instr0, (e.cnt >= 1) ? word_at(e.pc0) : 32'd0);
        chk($sformatf("v%0d.instr1", n), out_instr1, (e.cnt >= 2) ? word_at(e.pc1) : 32'd0);
      end
    end
  end

  initial begin
    int t;
    // deq, redir, rpc, pulse_rst, exp count, exp addr, exp pc0, exp pc1
    add(0, 0, 0, 0, 2, 32'h08, 32'h00, 32'h04);
    add(0, 0, 0, 0, 4, 32'h10, 32'h00, 32'h04);
    add(0, 0, 0, 0, 4, 32'h10, 32'h00, 32'h04);
    add(0, 0, 0, 0, 4, 32'h10, 32'h00, 32'h04);
    add(1, 0, 0, 0, 3, 32'h10, 32'h04, 32'h08);
    add(0, 0, 0, 0, 4, 32'h14, 32'h04, 32'h08);
    add(2, 0, 0, 0, 2, 32'h14, 32'h0C, 32'h10);
    add(2, 0, 0, 0, 2, 32'h1C, 32'h14, 32'h18);
    add(2, 0, 0, 0, 2, 32'h24, 32'h1C, 32'h20);
    add(2, 0, 0, 0, 2, 32'h2C, 32'h24, 32'h28);
    add(1, 0, 0, 0, 3, 32'h34, 32'h28, 32'h2C);
    add(0, 0, 0, 0, 4, 32'h38, 32'h28, 32'h2C);
    add(2, 1, 32'h43, 0, 0, 32'h40, 32'h00, 32'h00);
    add(0, 0, 0, 0, 2, 32'h48, 32'h40, 32'h44);
    add(1, 0, 0, 0, 3, 32'h50, 32'h44, 32'h48);
    add(2, 0, 0, 0, 2, 32'h54, 32'h4C, 32'h50);
    add(1, 0, 0, 0, 3, 32'h5C, 32'h50, 32'h54);
    add(3, 0, 0, 0, 2, 32'h60, 32'h58, 32'h5C);
    add(3, 0, 0, 0, 2, 32'h68, 32'h60, 32'h64);
    add(0, 0, 0, 0, 4, 32'h70, 32'h60, 32'h64);
    add(0, 0, 0, 1, 2, 32'h08, 32'h00, 32'h04);
    add(0, 1, 32'hFFFF_FFF8, 0, 0, 32'hFFFF_FFF8, 32'h0, 32'h0);
    add(0, 0, 0, 0, 2, 32'h00, 32'hFFFF_FFF8, 32'hFFFF_FFFC);
    add(2, 0, 0, 0, 2, 32'h08, 32'h00, 32'h04);

    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; deq_count = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");

    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].prst) begin
        rst_n = 1'b0;
        #2;
        chk_idle("midrst");
        #2;
      end
      rst_n       = 1'b1;
      deq_count   = 2'(vecs[i].deq);
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      expq.push_back(vecs[i]);
    end
    @(negedge clk);
    redirect = 1'b0; deq_count = 2'd0;

    t = 0;
    while (expq.size() > 0 && t < 10) begin
      @(posedge clk);
      t++;
    end
    #2;
    if (expq.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", expq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Dual-issue instruction fetch stage of the superscalar pipelined MIPS. Owns the program counter, drives the instruction memory address, captures the two words the memory returns (at PC and PC+4), and buffers them with their PCs in a small circular queue. Decode drains 0, 1 or 2 instructions per cycle. Branch/jump redirects flush the queue and restart fetch at the target.

## Interface
- DEPTH, 4: queue entries; power of two, ≥4.
- RESET_PC, 32'h0000_0000: PC loaded on reset; word-aligned.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  32  fetch PC to instruction memory; low 2 bits always 0.
- imem_rd  in  32  word at imem_addr; combinational, same cycle.
- imem_rd2  in  32  word at imem_addr+4; combinational, same cycle.
- redirect  in  1  flush and refetch from redirect_pc.
- redirect_pc  in  32  target PC; bits [1:0] ignored, treated as 0.
- deq_count  in  2  instructions consumed by decode this cycle (0,1,2; 3 treated as 2).
- out_valid0  out  1  slot 0 (oldest) holds an instruction.
- out_instr0  out  32  oldest instruction; 0 when out_valid0=0.
- out_pc0  out  32  PC of out_instr0; 0 when out_valid0=0.
- out_valid1  out  1  slot 1 (second oldest) valid.
- out_instr1  out  32  second instruction; 0 when out_valid1=0.
- out_pc1  out  32  PC of out_instr1; 0 when out_valid1=0.
- count  out  clog2(DEPTH)+1  occupied entries.

## Operation
- Registered state: pc, head, tail (mod DEPTH), count, DEPTH×{instr, pc} storage.
- imem_addr = pc (registered value, no combinational path from any input).
- free = DEPTH − count (registered count; this cycle's pops are not credited).
- push n = min(2, free): n=2 writes {imem_rd, pc} then {imem_rd2, pc+4}; n=1 writes {imem_rd, pc} only; n=0 writes nothing.
- pop m = min(deq_count clamped to 2, count); head advances by m.
- Next state: count ← count + n − m; tail ← tail + n; pc ← pc + 4·n (32-bit wrap, 32'hFFFF_FFFC + 4 → 0).
- Outputs decode from head: slot0 = entry[head], slot1 = entry[head+1 mod DEPTH]; out_valid0 = (count≥1), out_valid1 = (count≥2).
- Redirect (highest priority): head, tail, count ← 0; pc ← {redirect_pc[31:2],2'b00}; no push, pop ignored that cycle.
- Reset (any time, including mid-redirect): pc ← RESET_PC, head/tail/count ← 0, all outputs 0 while rst_n=0; storage contents need not be cleared.

## Timing
- Fetch→visible latency: word fetched at edge k is on out_* after edge k (1 cycle).
- First instruction after rst_n deasserts: valid after first rising edge.
- Redirect asserted in cycle k: outputs invalid after edge k; target instruction on out_instr0 after edge k+1.
- Full (count=DEPTH): no push, pc holds; a pop that cycle frees space used only next cycle.
- count=DEPTH−1: single push of imem_rd; pc advances by 4 only.
- deq_count > count: pops count entries, never underflows.
- Simultaneous push and pop of 2 with count=2: count stays 2, head and tail both wrap correctly.

## Structure
- Package fetch_pkg: INSTR_W=32, NOP constant 32'h0000_0000, default RESET_PC.
- Sub-module fetch_fifo: DEPTH-entry circular buffer, 2-wide push and 2-wide pop, exposes head two entries and count. ifetch_queue holds the PC, push/pop arbitration and redirect logic.

## Test plan
- Reset then free-run, memory word i = 32'h1000_0000+i, deq_count=2 each cycle → out_pc0/1 sequence 0/4, 8/C, …, instrs match, count steady at 2.
- deq_count=0 for 4 cycles from reset → count 2,4,4,4; imem_addr 0,8,10h,10h; no overwrite, out_instr0 stays word 0.
- count=3 (DEPTH=4), deq_count=0 → single push, count=4, imem_addr advances by 4.
- Redirect to 32'h0000_0043 while count=4 and deq_count=2 → next cycle count=0, valid=0, imem_addr=32'h40; following cycle out_pc0=40h, out_pc1=44h.
- deq_count=3 with count=1 → one pop, no underflow, count = 1 + n − 1.
- rst_n pulsed low mid-stream for half a cycle → outputs 0 immediately, imem_addr=RESET_PC, refetch from RESET_PC after release.
